// File: rtl/interlayer_row_reader.sv
// Interlayer buffer row reader: streams every feature-map row out of the
// buffer RAM, r-major with f inner, one assembled row per handshake.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module interlayer_row_reader #(
  parameter int BUFFER_DEPTH  = 4096,
  parameter int INPUT_SIZE    = 12,
  parameter int TOTAL_FEATURE = 20
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  output logic                                 rd_en_o,
  output logic [$clog2(BUFFER_DEPTH)-1:0]      rd_addr_o,
  input  logic [`DATA_WIDTH-1:0]               rd_data_i,
  output logic [INPUT_SIZE*`DATA_WIDTH-1:0]    row_o,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [$clog2(TOTAL_FEATURE)-1:0]     feature_idx_o,
  output logic [$clog2(INPUT_SIZE)-1:0]        feature_row_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int FW = $clog2(TOTAL_FEATURE);
  localparam int CW = $clog2(INPUT_SIZE);
  localparam int DW = `DATA_WIDTH;

  localparam logic [CW-1:0] COL_MAX = CW'(INPUT_SIZE - 1);
  localparam logic [FW-1:0] F_MAX   = FW'(TOTAL_FEATURE - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAST,
    OUT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] col;
  logic [CW-1:0] prev_col;
  logic          cap_vld;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] addr_calc;
  logic          hs;
  logic          last_row;

  assign hs       = (state == OUT) && ready_i;
  assign last_row = (feature_idx_o == F_MAX)
                 && (feature_row_o == COL_MAX);

  assign addr_calc = AW'(feature_idx_o) * AW'(INPUT_SIZE * INPUT_SIZE)
                   + AW'(feature_row_o) * AW'(INPUT_SIZE)
                   + AW'(col);

  assign rd_en_o   = (state == READ);
  assign rd_addr_o = rd_en_o ? addr_calc : last_addr;
  assign valid_o   = (state == OUT);
  assign busy_o    = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start_i) state_nx = READ;
      READ: if (col == COL_MAX) state_nx = LAST;
      LAST: state_nx = OUT;
      OUT:  if (ready_i) state_nx = last_row ? DONE : READ;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      col           <= '0;
      prev_col      <= '0;
      cap_vld       <= 1'b0;
      last_addr     <= '0;
      row_o         <= '0;
      feature_idx_o <= '0;
      feature_row_o <= '0;
      done_o        <= 1'b0;
    end else begin
      state    <= state_nx;
      cap_vld  <= rd_en_o;
      prev_col <= col;
      done_o   <= (state == DONE);
      if (state == IDLE && start_i) begin
        col           <= '0;
        feature_idx_o <= '0;
        feature_row_o <= '0;
      end
      if (rd_en_o) begin
        last_addr <= addr_calc;
        col       <= (col == COL_MAX) ? '0 : col + CW'(1);
      end
      // RAM data lags the address by one cycle, so land it in last cycle's column
      if (cap_vld)
        row_o[(INPUT_SIZE-1-int'(prev_col))*DW +: DW] <= rd_data_i;
      if (hs) begin
        if (feature_idx_o == F_MAX) begin
          feature_idx_o <= '0;
          feature_row_o <= last_row ? '0 : feature_row_o + 1'b1;
        end else begin
          feature_idx_o <= feature_idx_o + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/interlayer_row_reader.md
INTERLAYER_ROW_READER -- requirements
Module: interlayer_row_reader

Interface
REQ-001 SHALL have parameter BUFFER_DEPTH, default 4096, words in the interlayer buffer RAM.
REQ-002 SHALL have parameter INPUT_SIZE, default 12, feature-map width and height in words.
REQ-003 SHALL have parameter TOTAL_FEATURE, default 20, number of feature maps stored.
REQ-004 SHALL use one clock and a synchronous, active-high reset. There is no other clock or reset domain.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port start_i, input, 1 bit: single-cycle pulse that starts a full buffer readout.
REQ-008 SHALL have port rd_en_o, output, 1 bit: RAM read strobe.
REQ-009 SHALL have port rd_addr_o, output, logb2(BUFFER_DEPTH) bits: RAM read address.
REQ-010 SHALL have port rd_data_i, input, `DATA_WIDTH bits: RAM read data, valid 1 cycle after the rd_en_o/rd_addr_o cycle.
REQ-011 SHALL have port row_o, output, INPUT_SIZE*`DATA_WIDTH bits: assembled row; column c occupies bits (INPUT_SIZE-c)*`DATA_WIDTH-1 down to (INPUT_SIZE-c-1)*`DATA_WIDTH.
REQ-012 SHALL have port valid_o, output, 1 bit: row_o and its tags are valid.
REQ-013 SHALL have port ready_i, input, 1 bit: the downstream stage accepts the row.
REQ-014 SHALL have port feature_idx_o, output, logb2(TOTAL_FEATURE) bits: feature index of row_o.
REQ-015 SHALL have port feature_row_o, output, logb2(INPUT_SIZE) bits: row index of row_o.
REQ-016 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port done_o, output, 1 bit: one-cycle pulse after the last row is accepted.

Function
REQ-018 SHALL read word (f,r,c) from address f*INPUT_SIZE*INPUT_SIZE + r*INPUT_SIZE + c; TOTAL_FEATURE*INPUT_SIZE^2 <= BUFFER_DEPTH is a legal-parameter requirement.
REQ-019 SHALL implement the states IDLE, READ, LAST, OUT and DONE.
REQ-020 SHALL, in IDLE with start_i=1, clear the row, feature and column counters and go to READ; in all other states start_i is ignored.
REQ-021 SHALL, in READ, drive rd_en_o=1 and rd_addr_o=base(f,r)+col, and increment col each cycle. After col=INPUT_SIZE-1 is issued, it goes to LAST and col wraps to 0.
REQ-022 SHALL, in READ and LAST, capture rd_data_i into the row_o slot of the column issued in the previous cycle. LAST lasts one cycle, then the state goes to OUT.
REQ-023 SHALL hold valid_o=1 in OUT, with row_o, feature_idx_o and feature_row_o stable until valid_o and ready_i are both high in the same cycle.
REQ-024 SHALL, on handshake with f<TOTAL_FEATURE-1, increment f and go to READ.
REQ-025 SHALL, on handshake with f=TOTAL_FEATURE-1, set f to 0 and increment r. If r was INPUT_SIZE-1, it goes to DONE instead.
REQ-026 SHALL, in DONE, pulse done_o for one cycle and return to IDLE.
REQ-027 SHALL output rows in order row-major over r, with f inner: (r0,f0),(r0,f1),...,(r0,fTOTAL-1),(r1,f0),...
REQ-028 SHALL have this latency: valid_o first rises INPUT_SIZE+2 cycles after start_i is sampled, and INPUT_SIZE+2 cycles after each non-final handshake.
REQ-029 SHALL drive rd_en_o=0 outside READ; rd_addr_o holds its last value there.
REQ-030 SHALL give a full readout of TOTAL_FEATURE*INPUT_SIZE rows with ready_i held high a duration of TOTAL_FEATURE*INPUT_SIZE*(INPUT_SIZE+2)+2 cycles from start to the done_o pulse.

Reset
REQ-031 SHALL, on rst=1 at any clock edge (including mid-row or while valid_o is pending), go to IDLE. All counters go to 0.
REQ-032 SHALL reset these outputs to 0 on reset: row_o, valid_o, rd_en_o, rd_addr_o, feature_idx_o, feature_row_o, busy_o, done_o.
REQ-033 SHALL NOT resume an aborted readout after reset is released; a new start_i is required.

Verification
REQ-034 SHALL be verified for defaults with the RAM preloaded to mem[a]=a and ready_i=1. Required response: the first valid_o comes 14 cycles after start_i, with row_o words 0..11, feature_idx_o=0 and feature_row_o=0.
REQ-035 SHALL be verified over a full readout with ready_i=1. Required response: 240 rows are output. Row k=(r*20+f) holds words f*144+r*12+0..11. done_o pulses once at cycle 3362 and busy_o falls after it.
REQ-036 SHALL be verified with backpressure: ready_i=0 for 5 cycles while valid_o=1. Required response: row_o and the tags stay stable, rd_en_o stays 0, and the row is accepted on the first ready_i=1 cycle.
REQ-037 SHALL be verified at the wrap boundary: the handshake of (r=0,f=19) is followed by (r=1,f=0), whose first read address is 12.
REQ-038 SHALL be verified with start_i pulsed while busy_o=1. Required response: no effect on the sequence or the addresses.
REQ-039 SHALL be verified with rst asserted during READ of row (r=3,f=7). Required response: all outputs are 0 the next cycle and nothing happens until start_i. A new readout then begins at address 0.
